// File: rtl/ecdsa_scalar_prep.sv
// ECDSA verifier pre-stage: w = s^-1 mod N via constant-time Fermat exponentiation on a
// bit-serial modular multiplier, then u1 = e*w mod N and u2 = r*w mod N.
module ecdsa_scalar_prep #(
  parameter int unsigned W = 7,
  parameter int unsigned N = 83
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] r,
  input  logic [W-1:0] s,
  input  logic [W-1:0] e,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] w,
  output logic [W-1:0] u1,
  output logic [W-1:0] u2
);

  localparam int unsigned KW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [W:0]   NMod = (W + 1)'(N);
  localparam logic [W-1:0] Exp  = W'(N - 2);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCheck = 3'd1;
  localparam logic [2:0] StExp   = 3'd2;
  localparam logic [2:0] StU1    = 3'd3;
  localparam logic [2:0] StU2    = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  base_q, base_d;
  logic [W-1:0]  e_q, e_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  p_q, p_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] ebit_q, ebit_d;
  logic          phase_q, phase_d;
  logic [W-1:0]  w_q, w_d;
  logic [W-1:0]  u1_q, u1_d;
  logic [W-1:0]  u2_q, u2_d;
  logic          err_q, err_d;

  logic [W-1:0]  mm_a, mm_b, mm_res;
  logic          mm_bit;
  logic [W:0]    mm_dbl, mm_sum;

  // Shared multiplier operands: square uses acc twice, multiply uses acc*base.
  always_comb begin
    mm_a = acc_q;
    mm_b = w_q;
    if (state_q == StU1) begin
      mm_a = e_q;
    end else if (state_q == StU2) begin
      mm_a = r_q;
    end else if (state_q == StExp) begin
      mm_b = phase_q ? base_q : acc_q;
    end
    mm_bit = mm_b[k_q];
  end

  // One interleaved multiply step; p < N keeps every partial sum below 2N < 2^(W+1).
  always_comb begin
    mm_dbl = {p_q, 1'b0};
    if (mm_dbl >= NMod) mm_dbl = mm_dbl - NMod;
    mm_sum = mm_dbl + (mm_bit ? {1'b0, mm_a} : '0);
    if (mm_sum >= NMod) mm_sum = mm_sum - NMod;
    mm_res = mm_sum[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    base_d  = base_q;
    e_d     = e_q;
    acc_d   = acc_q;
    p_d     = p_q;
    k_d     = k_q;
    ebit_d  = ebit_q;
    phase_d = phase_q;
    w_d     = w_q;
    u1_d    = u1_q;
    u2_d    = u2_q;
    err_d   = err_q;

    case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) state_d = StIdle;
        if (start) begin
          state_d = StCheck;
          r_d     = r;
          base_d  = s;
          e_d     = e;
          w_d     = '0;
          u1_d    = '0;
          u2_d    = '0;
          err_d   = 1'b0;
        end
      end
      StCheck: begin
        if (r_q == '0 || {1'b0, r_q} >= NMod || base_q == '0 || {1'b0, base_q} >= NMod) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          // e < 2^W < 2N, so a single conditional subtract fully reduces it.
          e_d     = ({1'b0, e_q} >= NMod) ? (e_q - NMod[W-1:0]) : e_q;
          acc_d   = W'(1);
          p_d     = '0;
          k_d     = KW'(W - 1);
          ebit_d  = KW'(W - 1);
          phase_d = 1'b0;
          state_d = StExp;
        end
      end
      StExp: begin
        p_d = mm_res;
        if (k_q == '0) begin
          p_d = '0;
          k_d = KW'(W - 1);
          if (!phase_q) begin
            acc_d   = mm_res;
            phase_d = 1'b1;
          end else begin
            // Multiply always runs; only the keep decision depends on the exponent bit.
            if (Exp[ebit_q]) acc_d = mm_res;
            phase_d = 1'b0;
            if (ebit_q == '0) begin
              w_d     = Exp[ebit_q] ? mm_res : acc_q;
              state_d = StU1;
            end else begin
              ebit_d = ebit_q - 1'b1;
            end
          end
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      StU1, StU2: begin
        p_d = mm_res;
        if (k_q == '0) begin
          p_d = '0;
          k_d = KW'(W - 1);
          if (state_q == StU1) begin
            u1_d    = mm_res;
            state_d = StU2;
          end else begin
            u2_d    = mm_res;
            state_d = StDone;
          end
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      base_q  <= '0;
      e_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      k_q     <= '0;
      ebit_q  <= '0;
      phase_q <= 1'b0;
      w_q     <= '0;
      u1_q    <= '0;
      u2_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      base_q  <= base_d;
      e_q     <= e_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      k_q     <= k_d;
      ebit_q  <= ebit_d;
      phase_q <= phase_d;
      w_q     <= w_d;
      u1_q    <= u1_d;
      u2_q    <= u2_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == StCheck) || (state_q == StExp) || (state_q == StU1) ||
                (state_q == StU2);
  assign done = (state_q == StDone);
  assign err  = err_q;
  assign w    = w_q;
  assign u1   = u1_q;
  assign u2   = u2_q;

endmodule

// File: doc/ecdsa_scalar_prep.md
Name: ecdsa_scalar_prep

Overview:
- Sequential pre-stage of the ECDSA verifier.
- Accepts signature (r, s) and message digest e.
- Computes w = s^-1 mod n by Fermat exponentiation (s^(n-2)) on a bit-serial modular multiplier, then u1 = e*w mod n and u2 = r*w mod n.
- Feeds u1/u2 to the point-multiply/compare stage; replaces the table-lookup inverse with constant-time arithmetic.

Parameters:
W, 7, operand width in bits
N, 83, curve group order n; must be prime, N < 2^W, N > 2^(W-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
r  in  W  signature r
s  in  W  signature s
e  in  W  message digest, truncated to W bits
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse; results valid
err  out  1  sticky until next accepted start; r or s out of range
w  out  W  s^-1 mod N
u1  out  W  e*w mod N
u2  out  W  r*w mod N

Behaviour:
- Reset: all outputs 0; FSM = IDLE. Asynchronous assert; deassert synchronous to clk.
- Reset mid-operation: abort, outputs 0; no done pulse.
- Accept: start=1 and busy=0 at a rising edge. r, s, e captured into internal registers; later input changes ignored.
- start while busy=1: ignored, not queued.
- Outputs w/u1/u2/err hold their values until the next accepted start, then clear to 0 on that edge.
- FSM states:
  - IDLE -> CHECK on accept.
- CHECK (1 cycle):
  - If r==0, r>=N, s==0 or s>=N: err<=1, -> DONE.
  - Else: e_red <= (e>=N) ? e-N : e; acc<=1; base<=s; -> EXP.
- EXP: left-to-right over the W bits of N-2, MSB first. Per bit:
  - Square acc (W cycles).
  - Multiply acc*base (W cycles).
  - The product is kept only if the exponent bit is 1, else discarded.
  - Both multiplies always execute (constant time).
  - After the LSB: w<=acc, -> U1.
- U1: modmul(e_red, w), W cycles, u1<=result, -> U2.
- U2: modmul(r, w), W cycles, u2<=result, -> DONE.
- DONE (1 cycle): done=1, busy=0, -> IDLE.
- Modmul a*b mod N (a, b < N), one step per cycle, scanning b from MSB:
  - acc2 = 2*p; if acc2>=N subtract N.
  - If the b bit is set: acc2 += a; if >=N subtract N.
  - Internal width W+1 bits; no result ever >= N.
- Latency:
  - Valid path: done asserted exactly 2*W*W + 2*W + 2 cycles after the accept edge (W=7: 114).
  - Error path: done 2 cycles after accept; u1=u2=w=0.
- busy = 1 in CHECK, EXP, U1, U2; 0 in IDLE and DONE.
- start on the same edge as the done cycle (busy=0) is accepted; the new run begins and done deasserts.

Test Plan:
- Reset, then r=7, s=5, e=10, start pulse -> done after 114 cycles; w=50, u1=2, u2=18, err=0.
- r=82, s=82, e=100 -> w=82, u1=66 (e reduced to 17), u2=1, err=0.
- s=1, r=1, e=0 -> w=1, u1=0, u2=1; then s=2, r=41, e=83 -> w=42, u1=0, u2=62.
- s=0 (r=5) and separately r=83 (s=5) -> done 2 cycles after start, err=1, w=u1=u2=0; err clears on the next valid start.
- start re-pulsed at cycles 10 and 50 of a run -> ignored; single done at cycle 114 with the original operands' results.
- rst_n low at cycle 60 of a run, released, then new start r=7, s=5, e=10 -> no stale done; outputs 0 during reset; fresh run matches scenario 1.
